// File: rtl/cache_tag_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cache_tag_ctrl_pkg
//  Purpose  : Shared encodings for the cache tag table sequencer and arbiter.
//  Revision : 1.0  initial release
// ============================================================================
package cache_tag_ctrl_pkg;

    typedef enum logic [1:0] {
        FLAG_INVALID      = 2'd0,
        FLAG_SHARED_CLEAN = 2'd1,
        FLAG_OWNED_CLEAN  = 2'd2,
        FLAG_OWNED_DIRTY  = 2'd3
    } flag_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOK = 2'd1,
        ST_UPD  = 2'd2
    } state_e;

    localparam logic [1:0] c_op_read        = 2'd1;
    localparam logic [1:0] c_op_write       = 2'd2;
    localparam logic [1:0] c_op_fill        = 2'd3;

    localparam logic [1:0] c_snp_invalidate = 2'd1;
    localparam logic [1:0] c_snp_preempt    = 2'd2;

    // Winner one-hot bit positions
    localparam int c_win_cpu  = 0;
    localparam int c_win_snp1 = 1;
    localparam int c_win_snp2 = 2;

    function automatic logic is_dirty(input logic [1:0] flag);
        return flag == FLAG_OWNED_DIRTY;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cache_tag_ctrl_arb.sv
`default_nettype none
// ============================================================================
//  Module   : cache_tag_arb
//  Purpose  : Round-robin snoop arbiter with CPU starvation guard.
//  Revision : 1.0  initial release
// ============================================================================
module cache_tag_arb
    import cache_tag_ctrl_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       arb_en,
    input  logic       cpu_req,
    input  logic       snp_req_1,
    input  logic       snp_req_2,
    output logic [2:0] win
);

    logic       r_ptr;      // 0: channel 1 preferred, 1: channel 2 preferred
    logic [2:0] r_starve;
    logic       w_starved;

    assign w_starved = r_starve >= 3'(STARVE_LIMIT);

    always_comb begin
        win = '0;
        if (arb_en) begin
            if (cpu_req && w_starved) begin
                win[c_win_cpu] = 1'b1;
            end else if (snp_req_1 && (!r_ptr || !snp_req_2)) begin
                win[c_win_snp1] = 1'b1;
            end else if (snp_req_2) begin
                win[c_win_snp2] = 1'b1;
            end else if (cpu_req) begin
                win[c_win_cpu] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr    <= 1'b0;
            r_starve <= 3'd0;
        end else begin
            if (win[c_win_snp1]) begin
                r_ptr <= 1'b1;
            end else if (win[c_win_snp2]) begin
                r_ptr <= 1'b0;
            end

            if (win[c_win_cpu]) begin
                r_starve <= 3'd0;
            end else if ((win[c_win_snp1] || win[c_win_snp2]) && cpu_req && !w_starved) begin
                r_starve <= r_starve + 3'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : cache_tag_ctrl
//  Purpose  : Serialises CPU and snoop lookup/update transactions on the
//             single L1 tag table port and applies coherence flag updates.
//  Revision : 1.0  initial release
// ============================================================================
module cache_tag_ctrl
    import cache_tag_ctrl_pkg::*;
#(
    parameter int ENTRY_WIDTH    = 10,
    parameter int ADDR_TAG_WIDTH = 16,
    parameter int ADDR_P_WIDTH   = 32,
    parameter int STARVE_LIMIT   = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cpu_req,
    input  logic [1:0]                cpu_op,
    input  logic [ENTRY_WIDTH-1:0]    cpu_index,
    input  logic [ADDR_TAG_WIDTH-1:0] cpu_tag,
    input  logic [ADDR_P_WIDTH-1:0]   cpu_pa,
    output logic                      cpu_gnt,
    output logic                      cpu_done,
    output logic                      cpu_hit,
    output logic [1:0]                cpu_flag,
    output logic                      cpu_victim_dirty,
    input  logic                      snp_req_1,
    input  logic [ADDR_P_WIDTH-1:0]   snp_addr_1,
    input  logic [1:0]                snp_kind_1,
    output logic                      snp_gnt_1,
    output logic                      snp_done_1,
    output logic                      snp_hit_1,
    output logic                      snp_dirty_1,
    input  logic                      snp_req_2,
    input  logic [ADDR_P_WIDTH-1:0]   snp_addr_2,
    input  logic [1:0]                snp_kind_2,
    output logic                      snp_gnt_2,
    output logic                      snp_done_2,
    output logic                      snp_hit_2,
    output logic                      snp_dirty_2,
    output logic [ENTRY_WIDTH-1:0]    tt_index,
    output logic [ADDR_P_WIDTH-1:0]   tt_snp_addr,
    output logic                      tt_we_flag,
    output logic                      tt_we_addr,
    output logic [1:0]                tt_new_flag,
    output logic [ADDR_TAG_WIDTH-1:0] tt_new_addr_tag,
    output logic [ADDR_P_WIDTH-1:0]   tt_new_addr_p,
    input  logic [1:0]                tt_flag,
    input  logic [ADDR_TAG_WIDTH-1:0] tt_addr_tag,
    input  logic                      tt_snp_match,
    input  logic [1:0]                tt_snp_flag,
    input  logic [ENTRY_WIDTH-1:0]    tt_snp_index
);

    state_e                    r_state, w_state_nxt;
    logic [2:0]                r_win;
    logic [1:0]                r_op, r_kind;
    logic [ENTRY_WIDTH-1:0]    r_index, r_snp_index;
    logic [ADDR_TAG_WIDTH-1:0] r_tag, r_rd_tag;
    logic [ADDR_P_WIDTH-1:0]   r_pa;
    logic [1:0]                r_rd_flag, r_snp_flag;
    logic                      r_snp_match;

    logic [2:0]                w_win;
    logic                      w_cpu_v, w_arb_en, w_cpu_hit, w_snp_hit, w_snp_dirty;

    assign w_cpu_v     = cpu_req && (cpu_op != 2'd0);
    // Gating with rst keeps every grant low while reset is held.
    assign w_arb_en    = (r_state == ST_IDLE) && rst;
    assign w_cpu_hit   = (r_rd_flag != FLAG_INVALID) && (r_rd_tag == r_tag);
    assign w_snp_hit   = r_snp_match && (r_snp_flag != FLAG_INVALID);
    assign w_snp_dirty = w_snp_hit && is_dirty(r_snp_flag);

    cache_tag_arb #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_arb (
        .clk       (clk),
        .rst       (rst),
        .arb_en    (w_arb_en),
        .cpu_req   (w_cpu_v),
        .snp_req_1 (snp_req_1),
        .snp_req_2 (snp_req_2),
        .win       (w_win)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_win       <= '0;
            r_op        <= '0;
            r_kind      <= '0;
            r_index     <= '0;
            r_tag       <= '0;
            r_pa        <= '0;
            r_rd_flag   <= '0;
            r_rd_tag    <= '0;
            r_snp_match <= 1'b0;
            r_snp_flag  <= '0;
            r_snp_index <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_win != 3'b000) begin
                r_win   <= w_win;
                r_op    <= cpu_op;
                r_index <= cpu_index;
                r_tag   <= cpu_tag;
                r_kind  <= w_win[c_win_snp2] ? snp_kind_2 : snp_kind_1;
                r_pa    <= w_win[c_win_snp1] ? snp_addr_1 :
                           w_win[c_win_snp2] ? snp_addr_2 : cpu_pa;
            end
            if (r_state == ST_LOOK) begin
                r_rd_flag   <= tt_flag;
                r_rd_tag    <= tt_addr_tag;
                r_snp_match <= tt_snp_match;
                r_snp_flag  <= tt_snp_flag;
                r_snp_index <= tt_snp_index;
            end
        end
    end

    always_comb begin
        w_state_nxt      = r_state;
        cpu_gnt          = 1'b0;
        snp_gnt_1        = 1'b0;
        snp_gnt_2        = 1'b0;
        cpu_done         = 1'b0;
        cpu_hit          = 1'b0;
        cpu_flag         = 2'd0;
        cpu_victim_dirty = 1'b0;
        snp_done_1       = 1'b0;
        snp_hit_1        = 1'b0;
        snp_dirty_1      = 1'b0;
        snp_done_2       = 1'b0;
        snp_hit_2        = 1'b0;
        snp_dirty_2      = 1'b0;
        tt_index         = '0;
        tt_snp_addr      = '0;
        tt_we_flag       = 1'b0;
        tt_we_addr       = 1'b0;
        tt_new_flag      = FLAG_INVALID;
        tt_new_addr_tag  = '0;
        tt_new_addr_p    = '0;

        case (r_state)
            ST_IDLE: begin
                cpu_gnt   = w_win[c_win_cpu];
                snp_gnt_1 = w_win[c_win_snp1];
                snp_gnt_2 = w_win[c_win_snp2];
                if (w_win != 3'b000) begin
                    w_state_nxt = ST_LOOK;
                end
            end
            ST_LOOK: begin
                tt_index    = r_index;
                tt_snp_addr = r_pa;
                w_state_nxt = ST_UPD;
            end
            ST_UPD: begin
                w_state_nxt = ST_IDLE;
                if (r_win[c_win_cpu]) begin
                    tt_index = r_index;
                    cpu_done = 1'b1;
                    cpu_hit  = w_cpu_hit;
                    cpu_flag = r_rd_flag;
                    case (r_op)
                        c_op_write: begin
                            tt_we_flag  = w_cpu_hit;
                            tt_new_flag = w_cpu_hit ? FLAG_OWNED_DIRTY : FLAG_INVALID;
                        end
                        c_op_fill: begin
                            tt_we_flag       = 1'b1;
                            tt_we_addr       = 1'b1;
                            tt_new_flag      = FLAG_SHARED_CLEAN;
                            tt_new_addr_tag  = r_tag;
                            tt_new_addr_p    = r_pa;
                            cpu_victim_dirty = is_dirty(r_rd_flag);
                        end
                        default: ;
                    endcase
                end else begin
                    tt_index    = r_snp_index;
                    snp_done_1  = r_win[c_win_snp1];
                    snp_hit_1   = r_win[c_win_snp1] && w_snp_hit;
                    snp_dirty_1 = r_win[c_win_snp1] && w_snp_dirty;
                    snp_done_2  = r_win[c_win_snp2];
                    snp_hit_2   = r_win[c_win_snp2] && w_snp_hit;
                    snp_dirty_2 = r_win[c_win_snp2] && w_snp_dirty;
                    // Kinds 0 and 3 are probes: result only, no write.
                    if (w_snp_hit && r_kind == c_snp_invalidate) begin
                        tt_we_flag  = 1'b1;
                        tt_new_flag = FLAG_INVALID;
                    end else if (w_snp_hit && r_kind == c_snp_preempt) begin
                        tt_we_flag  = 1'b1;
                        tt_new_flag = FLAG_SHARED_CLEAN;
                    end
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_cache_tag_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_cache_tag_ctrl
//  Purpose  : Scoreboard bench for cache_tag_ctrl with a behavioural tag table.
//  Revision : 1.0  initial release
// ============================================================================
module tb_cache_tag_ctrl;

    localparam int EW = 10;
    localparam int TW = 16;
    localparam int PW = 32;
    localparam int NE = 1 << EW;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          cpu_req = 1'b0;
    logic [1:0]    cpu_op = 2'd0;
    logic [EW-1:0] cpu_index = '0;
    logic [TW-1:0] cpu_tag = '0;
    logic [PW-1:0] cpu_pa = '0;
    logic          snp_req_1 = 1'b0, snp_req_2 = 1'b0;
    logic [PW-1:0] snp_addr_1 = '0, snp_addr_2 = '0;
    logic [1:0]    snp_kind_1 = 2'd0, snp_kind_2 = 2'd0;
    logic          cpu_gnt, cpu_done, cpu_hit, cpu_victim_dirty;
    logic [1:0]    cpu_flag;
    logic          snp_gnt_1, snp_done_1, snp_hit_1, snp_dirty_1;
    logic          snp_gnt_2, snp_done_2, snp_hit_2, snp_dirty_2;
    logic [EW-1:0] tt_index, tt_snp_index;
    logic [PW-1:0] tt_snp_addr, tt_new_addr_p;
    logic          tt_we_flag, tt_we_addr, tt_snp_match;
    logic [1:0]    tt_new_flag, tt_flag, tt_snp_flag;
    logic [TW-1:0] tt_new_addr_tag, tt_addr_tag;

    always #5 clk = ~clk;

    cache_tag_ctrl #(
        .ENTRY_WIDTH(EW), .ADDR_TAG_WIDTH(TW), .ADDR_P_WIDTH(PW), .STARVE_LIMIT(4)
    ) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_op(cpu_op), .cpu_index(cpu_index), .cpu_tag(cpu_tag),
        .cpu_pa(cpu_pa), .cpu_gnt(cpu_gnt), .cpu_done(cpu_done), .cpu_hit(cpu_hit),
        .cpu_flag(cpu_flag), .cpu_victim_dirty(cpu_victim_dirty),
        .snp_req_1(snp_req_1), .snp_addr_1(snp_addr_1), .snp_kind_1(snp_kind_1),
        .snp_gnt_1(snp_gnt_1), .snp_done_1(snp_done_1), .snp_hit_1(snp_hit_1),
        .snp_dirty_1(snp_dirty_1),
        .snp_req_2(snp_req_2), .snp_addr_2(snp_addr_2), .snp_kind_2(snp_kind_2),
        .snp_gnt_2(snp_gnt_2), .snp_done_2(snp_done_2), .snp_hit_2(snp_hit_2),
        .snp_dirty_2(snp_dirty_2),
        .tt_index(tt_index), .tt_snp_addr(tt_snp_addr), .tt_we_flag(tt_we_flag),
        .tt_we_addr(tt_we_addr), .tt_new_flag(tt_new_flag),
        .tt_new_addr_tag(tt_new_addr_tag), .tt_new_addr_p(tt_new_addr_p),
        .tt_flag(tt_flag), .tt_addr_tag(tt_addr_tag), .tt_snp_match(tt_snp_match),
        .tt_snp_flag(tt_snp_flag), .tt_snp_index(tt_snp_index)
    );

    // Behavioural tag table: combinational read, write on rising edge
    logic [1:0]    t_flag [NE];
    logic [TW-1:0] t_tag  [NE];
    logic [PW-1:0] t_pa   [NE];
    logic          t_val  [NE];

    initial begin
        for (int i = 0; i < NE; i++) begin
            t_flag[i] = 2'd0; t_tag[i] = '0; t_pa[i] = '0; t_val[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        if (tt_we_flag) t_flag[tt_index] <= tt_new_flag;
        if (tt_we_addr) begin
            t_tag[tt_index] <= tt_new_addr_tag;
            t_pa[tt_index]  <= tt_new_addr_p;
            t_val[tt_index] <= 1'b1;
        end
    end

    assign tt_flag     = t_flag[tt_index];
    assign tt_addr_tag = t_tag[tt_index];

    always_comb begin
        tt_snp_match = 1'b0;
        tt_snp_index = '0;
        tt_snp_flag  = 2'd0;
        for (int i = NE - 1; i >= 0; i--) begin
            if (t_val[i] && t_pa[i] == tt_snp_addr) begin
                tt_snp_match = 1'b1;
                tt_snp_index = EW'(i);
                tt_snp_flag  = t_flag[i];
            end
        end
    end

    // Shadow table holding the expected coherence state
    logic [1:0]    sh_flag [NE];
    logic [TW-1:0] sh_tag  [NE];
    logic [PW-1:0] sh_pa   [NE];
    logic          sh_val  [NE];

    initial begin
        for (int i = 0; i < NE; i++) begin
            sh_flag[i] = 2'd0; sh_tag[i] = '0; sh_pa[i] = '0; sh_val[i] = 1'b0;
        end
    end

    typedef struct {
        logic [2:0]    src;
        int            gcyc;
        logic          hit;
        logic [1:0]    flag;
        logic          dirty;
        logic          we_flag;
        logic          we_addr;
        logic [1:0]    nf;
        logic [EW-1:0] idx;
        logic [TW-1:0] ntag;
        logic [PW-1:0] npa;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   cyc     = 0;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", name, got, exp, cyc);
        end
    endtask

    function automatic exp_t exp_cpu(input logic [1:0] op, input logic [EW-1:0] idx,
                                     input logic [TW-1:0] tag, input logic [PW-1:0] pa);
        exp_t e = '{default: 0};
        e.src  = 3'b001;
        e.idx  = idx;
        e.flag = sh_flag[idx];
        e.hit  = (e.flag != 2'd0) && (sh_tag[idx] == tag);
        if (op == 2'd2 && e.hit) begin
            e.we_flag = 1'b1;
            e.nf      = 2'd3;
        end
        if (op == 2'd3) begin
            e.we_flag = 1'b1;
            e.we_addr = 1'b1;
            e.nf      = 2'd1;
            e.ntag    = tag;
            e.npa     = pa;
            e.dirty   = (e.flag == 2'd3);
        end
        return e;
    endfunction

    function automatic exp_t exp_snp(input int ch, input logic [1:0] kind, input logic [PW-1:0] addr);
        exp_t e = '{default: 0};
        logic m = 1'b0;
        logic [EW-1:0] mi = '0;
        for (int i = 0; i < NE; i++) begin
            if (!m && sh_val[i] && sh_pa[i] == addr) begin
                m  = 1'b1;
                mi = EW'(i);
            end
        end
        e.src   = (ch == 1) ? 3'b010 : 3'b100;
        e.idx   = mi;
        e.hit   = m && (sh_flag[mi] != 2'd0);
        e.dirty = e.hit && (sh_flag[mi] == 2'd3);
        if (e.hit && kind == 2'd1) begin
            e.we_flag = 1'b1;
            e.nf      = 2'd0;
        end else if (e.hit && kind == 2'd2) begin
            e.we_flag = 1'b1;
            e.nf      = 2'd1;
        end
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: push on grant, pop and compare on done
    always @(negedge clk) begin : mon
        logic [2:0] g, d;
        exp_t e;
        if (rst) begin
            g = {snp_gnt_2, snp_gnt_1, cpu_gnt};
            d = {snp_done_2, snp_done_1, cpu_done};
            if (g != 3'b000) begin
                chk("gnt_onehot", 64'($countones(g)), 64'd1);
                chk("gnt_while_busy", 64'(sb.size()), 64'd0);
                if (g[0])      e = exp_cpu(cpu_op, cpu_index, cpu_tag, cpu_pa);
                else if (g[1]) e = exp_snp(1, snp_kind_1, snp_addr_1);
                else           e = exp_snp(2, snp_kind_2, snp_addr_2);
                e.gcyc = cyc;
                sb.push_back(e);
            end
            if (d != 3'b000) begin
                if (sb.size() == 0) begin
                    chk("unexpected_done", 64'(d), 64'd0);
                end else begin
                    e = sb.pop_front();
                    chk("done_src", 64'(d), 64'(e.src));
                    chk("done_latency", 64'(cyc - e.gcyc), 64'd2);
                    if (e.src[0])
                        chk("cpu_result", {cpu_hit, cpu_flag, cpu_victim_dirty}, {e.hit, e.flag, e.dirty});
                    else if (e.src[1])
                        chk("snp1_result", {snp_hit_1, snp_dirty_1}, {e.hit, e.dirty});
                    else
                        chk("snp2_result", {snp_hit_2, snp_dirty_2}, {e.hit, e.dirty});
                    chk("table_we", {tt_we_flag, tt_we_addr}, {e.we_flag, e.we_addr});
                    if (e.we_flag)
                        chk("new_flag_idx", {tt_new_flag, tt_index}, {e.nf, e.idx});
                    if (e.we_addr)
                        chk("fill_data", {tt_new_addr_tag, tt_new_addr_p}, {e.ntag, e.npa});
                    if (e.we_flag) sh_flag[e.idx] = e.nf;
                    if (e.we_addr) begin
                        sh_tag[e.idx] = e.ntag;
                        sh_pa[e.idx]  = e.npa;
                        sh_val[e.idx] = 1'b1;
                    end
                end
            end else if (tt_we_flag || tt_we_addr) begin
                chk("stray_we", 64'd1, 64'd0);
            end
        end
    end

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) chk("done_timeout", 64'(sb.size()), 64'd0);
        @(negedge clk);
    endtask

    task automatic cpu_txn(input logic [1:0] op, input logic [EW-1:0] idx,
                           input logic [TW-1:0] tag, input logic [PW-1:0] pa);
        int n = 0;
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_op = op; cpu_index = idx; cpu_tag = tag; cpu_pa = pa;
        do begin
            @(negedge clk);
            n++;
        end while (!cpu_gnt && n < 50);
        if (!cpu_gnt) chk("cpu_gnt_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_op = 2'd0;
        drain();
    endtask

    task automatic snp_txn(input int ch, input logic [1:0] kind, input logic [PW-1:0] addr);
        int n = 0;
        logic g;
        @(posedge clk); #1;
        if (ch == 1) begin snp_req_1 = 1'b1; snp_kind_1 = kind; snp_addr_1 = addr; end
        else         begin snp_req_2 = 1'b1; snp_kind_2 = kind; snp_addr_2 = addr; end
        do begin
            @(negedge clk);
            n++;
            g = (ch == 1) ? snp_gnt_1 : snp_gnt_2;
        end while (!g && n < 50);
        if (!g) chk("snp_gnt_timeout", 64'd0, 64'd1);
        @(posedge clk); #1;
        snp_req_1 = 1'b0; snp_req_2 = 1'b0;
        drain();
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int ord [5];
        int exp_ord [5];
        int k, n;
        exp_ord = '{1, 2, 1, 2, 0};

        // Reset state
        #12;
        chk("reset_ctl", {cpu_gnt, cpu_done, cpu_hit, cpu_flag, cpu_victim_dirty,
                          snp_gnt_1, snp_done_1, snp_hit_1, snp_dirty_1,
                          snp_gnt_2, snp_done_2, snp_hit_2, snp_dirty_2,
                          tt_we_flag, tt_we_addr, tt_new_flag}, 64'd0);
        chk("reset_data", {tt_index, tt_snp_addr, tt_new_addr_tag}, 64'd0);
        @(negedge clk); #2 rst = 1'b1;

        // 1: FILL into an invalid entry
        cpu_txn(2'd3, 10'd5, 16'h1234, 32'h0040_0050);
        chk("fill_entry5", {t_flag[5], t_tag[5], t_pa[5]}, {2'd1, 16'h1234, 32'h0040_0050});

        // 2: READ hit, WRITE upgrade to dirty, READ back
        cpu_txn(2'd1, 10'd5, 16'h1234, 32'h0);
        cpu_txn(2'd2, 10'd5, 16'h1234, 32'h0);
        chk("write_entry5", 64'(t_flag[5]), 64'd3);
        cpu_txn(2'd1, 10'd5, 16'h1234, 32'h0);
        cpu_txn(2'd1, 10'd5, 16'h1235, 32'h0);          // tag mismatch
        cpu_txn(2'd2, 10'd7, 16'h1234, 32'h0);          // write miss on invalid entry

        // 3: PREEMPT on a dirty line
        snp_txn(1, 2'd2, 32'h0040_0050);
        chk("preempt_entry5", 64'(t_flag[5]), 64'd1);

        // 5: INVALIDATE miss
        snp_txn(2, 2'd1, 32'h0080_0000);

        // 4: round robin plus starvation release
        @(posedge clk); #1;
        snp_req_1 = 1'b1; snp_kind_1 = 2'd0; snp_addr_1 = 32'h0040_0050;
        snp_req_2 = 1'b1; snp_kind_2 = 2'd2; snp_addr_2 = 32'h0040_0050;
        cpu_req   = 1'b1; cpu_op = 2'd1; cpu_index = 10'd5; cpu_tag = 16'h1234;
        k = 0; n = 0;
        while (k < 5 && n < 60) begin
            @(negedge clk);
            n++;
            if (snp_gnt_1)      begin ord[k] = 1; k++; end
            else if (snp_gnt_2) begin ord[k] = 2; k++; end
            else if (cpu_gnt)   begin ord[k] = 0; k++; end
        end
        chk("arb_grant_count", 64'(k), 64'd5);
        for (int i = 0; i < k; i++) chk($sformatf("grant_order%0d", i), 64'(ord[i]), 64'(exp_ord[i]));
        @(posedge clk); #1;
        snp_req_1 = 1'b0; snp_req_2 = 1'b0; cpu_req = 1'b0; cpu_op = 2'd0;
        drain();

        // 6: reset during LOOK of a WRITE
        @(posedge clk); #1;
        cpu_req = 1'b1; cpu_op = 2'd2; cpu_index = 10'd5; cpu_tag = 16'h1234;
        n = 0;
        do begin @(negedge clk); n++; end while (!cpu_gnt && n < 50);
        chk("rst_txn_gnt", 64'(cpu_gnt), 64'd1);
        @(posedge clk); #1;
        cpu_req = 1'b0; cpu_op = 2'd0;
        #1 rst = 1'b0;
        #1;
        sb.delete();
        chk("midrst_ctl", {cpu_gnt, cpu_done, cpu_hit, cpu_flag, cpu_victim_dirty,
                           snp_gnt_1, snp_done_1, snp_hit_1, snp_dirty_1,
                           snp_gnt_2, snp_done_2, snp_hit_2, snp_dirty_2,
                           tt_we_flag, tt_we_addr, tt_new_flag}, 64'd0);
        chk("midrst_data", {tt_index, tt_snp_addr, tt_new_addr_tag}, 64'd0);
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        repeat (5) @(negedge clk);
        chk("midrst_no_write", 64'(t_flag[5]), 64'd1);
        cpu_txn(2'd1, 10'd5, 16'h1234, 32'h0);

        // FILL over a dirty victim
        cpu_txn(2'd2, 10'd5, 16'h1234, 32'h0);
        cpu_txn(2'd3, 10'd5, 16'hBEEF, 32'h0040_0090);
        chk("refill_entry5", {t_flag[5], t_tag[5], t_pa[5]}, {sh_flag[5], sh_tag[5], sh_pa[5]});
        chk("refill_flag", 64'(t_flag[5]), 64'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/cache_tag_ctrl.md
Name: cache_tag_ctrl

Overview:
- Sequencer and arbiter in front of the L1 cache tag table. It shares the single table port between one CPU/MEM requester and two snoop channels.
- Runs lookup-then-update transactions one at a time, so table reads and writes never overlap.
- Applies the coherence flag transitions (INVALID/SHARED_CLEAN/OWNED_CLEAN/OWNED_DIRTY) and returns hit, flag and dirty-writeback indications.

Parameters:
ENTRY_WIDTH, 10, table index width (1K entries)
ADDR_TAG_WIDTH, 16, address tag width
ADDR_P_WIDTH, 32, physical address width
STARVE_LIMIT, 4, consecutive snoop grants allowed while a CPU request waits

Ports:
clk  in  1  clock; all state changes on rising edge
rst  in  1  reset; asynchronous, active-low
cpu_req  in  1  CPU/MEM request valid
cpu_op  in  2  1=READ, 2=WRITE, 3=FILL (0 is ignored, treated as no request)
cpu_index  in  ENTRY_WIDTH  table index
cpu_tag  in  ADDR_TAG_WIDTH  request tag
cpu_pa  in  ADDR_P_WIDTH  physical address (used by FILL)
cpu_gnt  out  1  request accepted this cycle
cpu_done  out  1  one-cycle result pulse
cpu_hit  out  1  flag!=INVALID and tag match
cpu_flag  out  2  flag read at lookup
cpu_victim_dirty  out  1  FILL replaced an OWNED_DIRTY entry
snp_req_1/snp_req_2  in  1  snoop request valid
snp_addr_1/snp_addr_2  in  ADDR_P_WIDTH  snooped physical address
snp_kind_1/snp_kind_2  in  2  1=INVALIDATE_SIGNAL, 2=PREEMPT
snp_gnt_1/snp_gnt_2  out  1  snoop accepted
snp_done_1/snp_done_2  out  1  one-cycle result pulse
snp_hit_1/snp_hit_2  out  1  table match found
snp_dirty_1/snp_dirty_2  out  1  matched entry was OWNED_DIRTY (writeback needed)
tt_index  out  ENTRY_WIDTH  to table index
tt_snp_addr  out  ADDR_P_WIDTH  to table snoop address port 1
tt_we_flag, tt_we_addr  out  1  table write enables
tt_new_flag  out  2;  tt_new_addr_tag  out  ADDR_TAG_WIDTH;  tt_new_addr_p  out  ADDR_P_WIDTH
tt_flag  in  2;  tt_addr_tag  in  ADDR_TAG_WIDTH  table read data
tt_snp_match  in  1;  tt_snp_flag  in  2;  tt_snp_index  in  ENTRY_WIDTH  table snoop result

Behaviour:
- Reset: state IDLE; every gnt, done, hit, dirty and tt_we_* output is 0; tt_* data outputs are 0; starve count 0; snoop round-robin pointer selects channel 1.
- FSM states:
  - IDLE: arbitrate; the winner's gnt is high this cycle; its operands are latched; go to LOOK.
  - LOOK: latched index/address driven onto tt_*; table outputs registered at the edge; go to UPD.
  - UPD: write enables are pulsed for exactly this cycle; the winner's done is asserted with its result; go to IDLE.
- Handshake: a transfer occurs on req&&gnt. The requester holds operands until gnt and may drop req the following cycle. done arrives 2 cycles after gnt. Grants happen only in IDLE, so the minimum spacing between grants is 3 cycles.
- Arbitration: snoops beat the CPU. Between the two snoops, round-robin; the pointer toggles to the other channel after each snoop grant.
- CPU starvation: while cpu_req is pending, each snoop grant increments the starve count. At STARVE_LIMIT, the CPU wins the next IDLE and the count clears. The count also clears on any CPU grant.
- CPU READ: hit = (tt_flag!=0)&&(tt_addr_tag==tag); no write.
- CPU WRITE: on hit, tt_we_flag=1 and new flag OWNED_DIRTY; on miss, no write and hit=0.
- CPU FILL: tt_we_flag=tt_we_addr=1, tag/pa written, new flag SHARED_CLEAN. cpu_victim_dirty = (old flag==OWNED_DIRTY). cpu_hit reports the pre-fill lookup.
- Snoop on match, INVALIDATE: new flag INVALID.
- Snoop on match, PREEMPT: OWNED_CLEAN or OWNED_DIRTY becomes SHARED_CLEAN. SHARED_CLEAN is rewritten unchanged; INVALID gets no write.
- Snoop write side effects: tt_index = tt_snp_index during UPD. snp_dirty = (matched flag==OWNED_DIRTY).
- Snoop miss, or a match on an INVALID entry: hit=0, dirty=0, no write.
- snp_kind 0 or 3: treated as a probe; hit/dirty reported, no write.
- Serialisation: a snoop and a CPU request to the same entry are serialised. The later transaction observes the earlier transaction's write.
- Reset mid-transaction: the transaction is dropped and no done is issued. The requester must re-request.
- Width rules: tag compare is exact over ADDR_TAG_WIDTH. Starve count is 3 bits and saturates at STARVE_LIMIT.

Decomposition:
- Shared package/define file holds: flag encodings (INVALID=0, SHARED_CLEAN=1, OWNED_CLEAN=2, OWNED_DIRTY=3), snoop kinds (INVALIDATE_SIGNAL=1, PREEMPT=2), CPU op codes and FSM state encodings.
- One natural sub-module: cache_tag_arb, the round-robin snoop arbiter plus starvation counter, producing the winner one-hot. The FSM and datapath stay in cache_tag_ctrl.

Test Plan:
1. After reset, FILL index 5, tag 0x1234, pa 0x00400050 on an INVALID entry -> gnt, then done 2 cycles later with hit=0, victim_dirty=0; table entry 5 = SHARED_CLEAN/0x1234.
2. READ index 5, tag 0x1234 -> hit=1, flag=1. Then WRITE the same -> tt_we_flag pulse with flag 3. A later READ returns flag=3.
3. snp_req_1 PREEMPT on 0x00400050 with entry 5 OWNED_DIRTY -> snp_hit_1=1, snp_dirty_1=1, entry 5 becomes SHARED_CLEAN; cpu_gnt stays 0 during the transaction.
4. snp_req_1 and snp_req_2 held high continuously -> grants alternate 1,2,1,2. With cpu_req also pending, the CPU is granted after 4 snoop grants.
5. INVALIDATE to an address not present -> snp_hit=0, no tt_we_* pulse, done after 2 cycles.
6. rst low during LOOK of a WRITE -> no done and no table write; all outputs 0. After rst high, a re-issued READ completes normally.
